// File: rtl/fft_frame_serializer.sv
// Captures a complete reordered FFT frame in one cycle and replays it as
// LANES-wide beats in natural order under a valid/ready handshake.
module fft_frame_serializer #(
   parameter int DW    = 13,
   parameter int N     = 512,
   parameter int LANES = 16,
   localparam int BEATS = N / LANES,
   localparam int BW    = $clog2(BEATS)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        valid_in,
   input  logic [N-1:0][DW-1:0]        din_re,
   input  logic [N-1:0][DW-1:0]        din_im,
   input  logic                        ready_in,
   input  logic                        clr_ovf,
   output logic                        valid_out,
   output logic [LANES-1:0][DW-1:0]    dout_re,
   output logic [LANES-1:0][DW-1:0]    dout_im,
   output logic [BW-1:0]               beat_idx,
   output logic                        sof,
   output logic                        eof,
   output logic                        busy,
   output logic                        overflow
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        beatCnt_q, beatCnt_d;
   logic                 overflow_q, overflow_d;
   logic [N-1:0][DW-1:0] bufRe_q, bufIm_q;
   logic                 xfer, lastBeat, capture, drop;

   assign xfer     = (state_q == SEND) && ready_in;
   assign lastBeat = (beatCnt_q == BW'(BEATS - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         beatCnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         beatCnt_q  <= beatCnt_d;
         overflow_q <= overflow_d;
      end
   end

   // A new frame is only accepted when the buffer is free or being vacated this very edge.
   always_comb begin
      state_d    = state_q;
      beatCnt_d  = beatCnt_q;
      capture    = 1'b0;
      drop       = 1'b0;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               capture   = 1'b1;
               beatCnt_d = '0;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (xfer && lastBeat) begin
               beatCnt_d = '0;
               if (valid_in) begin
                  capture = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (xfer) begin
                  beatCnt_d = beatCnt_q + 1'b1;
               end
               if (valid_in) begin
                  drop = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bufRe_q <= '0;
         bufIm_q <= '0;
      end else if (capture) begin
         bufRe_q <= din_re;
         bufIm_q <= din_im;
      end
   end

   // Outputs derive only from registered state, so a stall holds them for free.
   assign valid_out = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign overflow  = overflow_q;
   assign dout_re   = valid_out ? bufRe_q[beatCnt_q*LANES +: LANES] : '0;
   assign dout_im   = valid_out ? bufIm_q[beatCnt_q*LANES +: LANES] : '0;
   assign beat_idx  = valid_out ? beatCnt_q : '0;
   assign sof       = valid_out && (beatCnt_q == '0);
   assign eof       = valid_out && lastBeat;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed self-checking bench for fft_frame_serializer: streaming, stalls,
// back-to-back frames, overflow handling and mid-frame reset.
module tb_fft_frame_serializer;

   localparam int DW    = 13;
   localparam int N     = 512;
   localparam int LANES = 16;

   logic                     clk;
   logic                     rstn;
   logic                     valid_in;
   logic [N-1:0][DW-1:0]     din_re;
   logic [N-1:0][DW-1:0]     din_im;
   logic                     ready_in;
   logic                     clr_ovf;
   logic                     valid_out;
   logic [LANES-1:0][DW-1:0] dout_re;
   logic [LANES-1:0][DW-1:0] dout_im;
   logic [4:0]               beat_idx;
   logic                     sof;
   logic                     eof;
   logic                     busy;
   logic                     overflow;

   int checkCount = 0;
   int failCount  = 0;

   fft_frame_serializer #(.DW(DW), .N(N), .LANES(LANES)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .valid_in  (valid_in),
      .din_re    (din_re),
      .din_im    (din_im),
      .ready_in  (ready_in),
      .clr_ovf   (clr_ovf),
      .valid_out (valid_out),
      .dout_re   (dout_re),
      .dout_im   (dout_im),
      .beat_idx  (beat_idx),
      .sof       (sof),
      .eof       (eof),
      .busy      (busy),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; everything is driven and sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Frame with re[i] = base+i and im[i] = -(base+i), wrapped to DW bits.
   task automatic loadFrame(input int base);
      for (int i = 0; i < N; i++) begin
         din_re[i] = DW'(base + i);
         din_im[i] = DW'(-(base + i));
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; valid_in = 1'b0; ready_in = 1'b0; clr_ovf = 1'b0;
      loadFrame(0);
      #12;
      checkCount++;
      if (valid_out !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid_out); end
      checkCount++;
      if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
      checkCount++;
      if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ovf: got %0b expected 0", overflow); end
      checkCount++;
      if ({sof, eof, beat_idx} !== 7'd0) begin failCount++; $display("[TB] FAIL reset_flags: got sof=%0b eof=%0b idx=%0d expected 0", sof, eof, beat_idx); end
      checkCount++;
      if (dout_re !== '0 || dout_im !== '0) begin failCount++; $display("[TB] FAIL reset_dout: got re0=%0d im0=%0d expected 0", dout_re[0], dout_im[0]); end
      rstn = 1'b1;
      step();
      ready_in = 1'b1;
      step();
      checkCount++;
      if (valid_out !== 1'b0) begin failCount++; $display("[TB] FAIL idle_ready_ignored: got %0b expected 0", valid_out); end
   endtask

   task automatic test_stream();
      logic [DW-1:0] expRe, expIm;
      loadFrame(0);
      ready_in = 1'b1;
      valid_in = 1'b1;
      checkCount++;
      if (valid_out !== 1'b0) begin failCount++; $display("[TB] FAIL stream_pre_valid: got %0b expected 0", valid_out); end
      step();
      valid_in = 1'b0;
      for (int k = 0; k < 32; k++) begin
         checkCount++;
         if (valid_out !== 1'b1 || busy !== 1'b1) begin failCount++; $display("[TB] FAIL stream_valid beat %0d: got valid=%0b busy=%0b expected 1", k, valid_out, busy); end
         checkCount++;
         if (beat_idx !== 5'(k)) begin failCount++; $display("[TB] FAIL stream_idx: got %0d expected %0d", beat_idx, k); end
         checkCount++;
         if (sof !== (k == 0) || eof !== (k == 31)) begin failCount++; $display("[TB] FAIL stream_sof_eof beat %0d: got sof=%0b eof=%0b", k, sof, eof); end
         for (int j = 0; j < LANES; j++) begin
            expRe = DW'(16 * k + j);
            expIm = DW'(-(16 * k + j));
            checkCount++;
            if (dout_re[j] !== expRe || dout_im[j] !== expIm) begin
               failCount++;
               $display("[TB] FAIL stream_data beat %0d lane %0d: got re=%0d im=%0d expected re=%0d im=%0d", k, j, dout_re[j], dout_im[j], expRe, expIm);
            end
         end
         step();
      end
      checkCount++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL stream_end: got valid=%0b busy=%0b expected 0", valid_out, busy); end
   endtask

   task automatic test_stall();
      logic [3:0] pattern;
      int nextBeat, validCycles, stalls;
      pattern = 4'b1001;
      nextBeat = 0; validCycles = 0; stalls = 0;
      loadFrame(0);
      ready_in = 1'b1;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int c = 0; c < 200 && valid_out; c++) begin
         validCycles++;
         checkCount++;
         if (beat_idx !== 5'(nextBeat)) begin failCount++; $display("[TB] FAIL stall_idx: got %0d expected %0d", beat_idx, nextBeat); end
         checkCount++;
         if (dout_re[0] !== DW'(16 * nextBeat) || dout_im[15] !== DW'(-(16 * nextBeat + 15))) begin
            failCount++;
            $display("[TB] FAIL stall_data: got re0=%0d im15=%0d for beat %0d", dout_re[0], dout_im[15], nextBeat);
         end
         checkCount++;
         if (sof !== (nextBeat == 0) || eof !== (nextBeat == 31)) begin failCount++; $display("[TB] FAIL stall_sof_eof beat %0d: got sof=%0b eof=%0b", nextBeat, sof, eof); end
         ready_in = pattern[3 - (c % 4)];
         if (ready_in) nextBeat++;
         else stalls++;
         step();
      end
      checkCount++;
      if (nextBeat !== 32 || valid_out !== 1'b0) begin failCount++; $display("[TB] FAIL stall_beats: got %0d beats valid=%0b expected 32 beats then idle", nextBeat, valid_out); end
      checkCount++;
      if (validCycles !== 32 + stalls) begin failCount++; $display("[TB] FAIL stall_cycles: got %0d expected %0d", validCycles, 32 + stalls); end
      ready_in = 1'b1;
   endtask

   task automatic test_back_to_back();
      loadFrame(0);
      ready_in = 1'b1;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int k = 0; k < 31; k++) step();
      checkCount++;
      if (beat_idx !== 5'd31 || eof !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_last: got idx=%0d eof=%0b expected 31/1", beat_idx, eof); end
      loadFrame(1000);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      checkCount++;
      if (valid_out !== 1'b1 || beat_idx !== 5'd0 || sof !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_bubble: got valid=%0b idx=%0d sof=%0b expected 1/0/1", valid_out, beat_idx, sof); end
      checkCount++;
      if (dout_re[0] !== DW'(1000) || dout_im[0] !== DW'(-1000)) begin failCount++; $display("[TB] FAIL b2b_data: got re0=%0d im0=%0d expected 1000/-1000", dout_re[0], dout_im[0]); end
      checkCount++;
      if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_ovf: got %0b expected 0", overflow); end
      step();
      checkCount++;
      if (dout_re[15] !== DW'(1031)) begin failCount++; $display("[TB] FAIL b2b_beat1: got re15=%0d expected 1031", dout_re[15]); end
      for (int k = 0; k < 40 && valid_out; k++) step();
      checkCount++;
      if (valid_out !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_drain: got %0b expected 0", valid_out); end
   endtask

   task automatic test_overflow();
      loadFrame(0);
      ready_in = 1'b1;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int k = 0; k < 10; k++) step();
      loadFrame(3000);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      checkCount++;
      if (beat_idx !== 5'd11 || dout_re[0] !== DW'(176)) begin failCount++; $display("[TB] FAIL ovf_stream: got idx=%0d re0=%0d expected 11/176", beat_idx, dout_re[0]); end
      checkCount++;
      if (overflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_set: got %0b expected 1", overflow); end
      step();
      checkCount++;
      if (overflow !== 1'b1 || dout_re[0] !== DW'(192)) begin failCount++; $display("[TB] FAIL ovf_sticky: got ovf=%0b re0=%0d expected 1/192", overflow, dout_re[0]); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      checkCount++;
      if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_clear: got %0b expected 0", overflow); end
      clr_ovf = 1'b1;
      valid_in = 1'b1;
      step();
      clr_ovf = 1'b0;
      valid_in = 1'b0;
      checkCount++;
      if (overflow !== 1'b1 || beat_idx !== 5'd14) begin failCount++; $display("[TB] FAIL ovf_set_wins: got ovf=%0b idx=%0d expected 1/14", overflow, beat_idx); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      checkCount++;
      if (overflow !== 1'b0 || dout_re[0] !== DW'(240)) begin failCount++; $display("[TB] FAIL ovf_reclear: got ovf=%0b re0=%0d expected 0/240", overflow, dout_re[0]); end
      for (int k = 0; k < 40 && valid_out; k++) step();
      checkCount++;
      if (valid_out !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_drain: got %0b expected 0", valid_out); end
   endtask

   task automatic test_reset_mid();
      loadFrame(0);
      ready_in = 1'b1;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int k = 0; k < 15; k++) step();
      ready_in = 1'b0;
      step();
      checkCount++;
      if (beat_idx !== 5'd15 || dout_re[0] !== DW'(240)) begin failCount++; $display("[TB] FAIL rst_hold: got idx=%0d re0=%0d expected 15/240", beat_idx, dout_re[0]); end
      #2 rstn = 1'b0;
      #1;
      checkCount++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_async: got valid=%0b busy=%0b expected 0", valid_out, busy); end
      checkCount++;
      if (dout_re !== '0 || dout_im !== '0 || beat_idx !== 5'd0) begin failCount++; $display("[TB] FAIL rst_dout: got re0=%0d idx=%0d expected 0", dout_re[0], beat_idx); end
      #3 rstn = 1'b1;
      ready_in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         checkCount++;
         if (valid_out !== 1'b0) begin failCount++; $display("[TB] FAIL rst_idle: got %0b expected 0", valid_out); end
      end
      loadFrame(500);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      checkCount++;
      if (valid_out !== 1'b1 || beat_idx !== 5'd0 || sof !== 1'b1 || dout_re[0] !== DW'(500)) begin
         failCount++;
         $display("[TB] FAIL rst_restart: got valid=%0b idx=%0d sof=%0b re0=%0d expected 1/0/1/500", valid_out, beat_idx, sof, dout_re[0]);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
